// File: rtl/bsram_rd_pkg.sv
// Shared constants and types for the BSRAM port-B burst reader.
// The optional checksum helper is used when RD_CHECKSUM_EN is defined.
package bsram_rd_pkg;

    localparam int BSRAM_ADDR_W = 13;
    localparam int BSRAM_DATA_W = 8;
    localparam logic [BSRAM_ADDR_W-1:0] BSRAM_MASK = 13'h1FFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_e;

    // Modulo-256 running sum of streamed bytes.
    function automatic logic [BSRAM_DATA_W-1:0] csum8_add(
        input logic [BSRAM_DATA_W-1:0] acc,
        input logic [BSRAM_DATA_W-1:0] b
    );
        return acc + b;
    endfunction

endpackage

// File: rtl/bsram_burst_reader_rd_fifo.sv
// Small synchronous FIFO between the BSRAM read pipe and the valid/ready stream.
// Push and pop may coincide, also when full or empty; there is no empty bypass.
module rd_fifo
    import bsram_rd_pkg::*;
#(
    parameter int DATA_W = BSRAM_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          push_data_i,
    input  logic                       pop_i,
    output logic [DATA_W-1:0]          pop_data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o,
    output logic                       full_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push_s, do_pop_s;

    // Pointer, count and storage next-state.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        do_pop_s  = pop_i && (count_q != '0);
        do_push_s = push_i && ((count_q != CW'(DEPTH)) || do_pop_s);
        if (do_push_s) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers; storage is cleared so the head reads zero after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CW'(DEPTH));

endmodule

// File: rtl/bsram_burst_reader.sv
// BSRAM port-B burst reader: issues sequential reads, absorbs RAM latency, streams bytes out.
// Optional feature macro RD_CHECKSUM_EN adds a per-burst 8-bit byte sum on checksum.
module bsram_burst_reader
    import bsram_rd_pkg::*;
#(
    parameter int ADDR_W       = BSRAM_ADDR_W,
    parameter int DATA_W       = BSRAM_DATA_W,
    parameter int LEN_W        = 9,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              MEMORY_CLK,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  burst_len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] adb,
    output logic              ceb,
    output logic              oce,
    output logic              resetb,
    input  logic [DATA_W-1:0] dout,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic [DATA_W-1:0] checksum
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int FW = CW + 1;

    rd_state_e               state_q, state_d;
    logic [ADDR_W-1:0]       base_q, base_d, adb_q, adb_d;
    logic [LEN_W-1:0]        len_q, len_d, idx_q, idx_d;
    logic                    ceb_q, ceb_d, busy_q, busy_d, done_q, done_d;
    logic [READ_LATENCY-1:0] pipe_q, pipe_d;
    logic [READ_LATENCY:0]   pipe_ext_s;

    logic [CW-1:0]     fifo_count_s, inflight_s;
    logic [FW-1:0]     free_s;
    logic [DATA_W-1:0] fifo_head_s;
    logic              fifo_empty_s, fifo_full_s, push_s, pop_s;
    logic              credit_ok_s, drain_done_s, start_acc_s;

    assign push_s      = pipe_q[READ_LATENCY-1];
    assign pop_s       = !fifo_empty_s && m_ready;
    assign start_acc_s = (state_q == IDLE) && start;

    // Reads in flight: the one on the RAM port plus every bit in the latency pipe.
    always_comb begin
        inflight_s = CW'(ceb_q);
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight_s = inflight_s + CW'(pipe_q[i]);
        end
    end

    // A pop this edge frees a slot in time for a read issued now, keeping full throughput.
    assign free_s       = FW'(FIFO_DEPTH) - FW'(fifo_count_s) + FW'(pop_s);
    assign credit_ok_s  = (free_s > FW'(inflight_s)) && !(fifo_full_s && !pop_s);
    assign drain_done_s = !ceb_q && (pipe_q == '0) &&
                          ((fifo_count_s == '0) || ((fifo_count_s == CW'(1)) && pop_s));

    assign pipe_ext_s = {pipe_q, ceb_q};

    // Burst FSM next-state and read-port controls.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        idx_d   = idx_q;
        adb_d   = adb_q;
        ceb_d   = 1'b0;
        pipe_d  = pipe_ext_s[READ_LATENCY-1:0];
        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d = start_addr;
                    len_d  = burst_len;
                    idx_d  = '0;
                    if (burst_len == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (credit_ok_s) begin
                    ceb_d = 1'b1;
                    adb_d = base_q + ADDR_W'(idx_q);
                    idx_d = idx_q + LEN_W'(1);
                    if ((idx_q + LEN_W'(1)) == len_q) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = ISSUE;
                    end
                end else begin
                    ceb_d = 1'b0;
                end
            end
            DRAIN: begin
                if (drain_done_s) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // Control and read-port registers.
    always_ff @(posedge MEMORY_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            adb_q   <= '0;
            ceb_q   <= 1'b0;
            pipe_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            adb_q   <= adb_d;
            ceb_q   <= ceb_d;
            pipe_q  <= pipe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    rd_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (MEMORY_CLK),
        .rst_ni      (rst_n),
        .push_i      (push_s),
        .push_data_i (dout),
        .pop_i       (pop_s),
        .pop_data_o  (fifo_head_s),
        .count_o     (fifo_count_s),
        .empty_o     (fifo_empty_s),
        .full_o      (fifo_full_s)
    );

`ifdef RD_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;

    // Sum restarts on an accepted start and holds once the burst has drained.
    always_comb begin
        if (start_acc_s) begin
            csum_d = '0;
        end else if (pop_s) begin
            csum_d = csum8_add(csum_q, fifo_head_s);
        end else begin
            csum_d = csum_q;
        end
    end

    // Checksum register.
    always_ff @(posedge MEMORY_CLK or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`else
    logic unused_start_acc_s;
    assign unused_start_acc_s = start_acc_s;
    assign checksum           = '0;
`endif

    assign busy    = busy_q;
    assign done    = done_q;
    assign adb     = adb_q;
    assign ceb     = ceb_q;
    assign oce     = 1'b1;
    assign resetb  = 1'b0;
    assign m_valid = !fifo_empty_s;
    assign m_data  = fifo_head_s;

endmodule

// File: tb/tb_bsram_burst_reader.sv
// Bench for bsram_burst_reader: pipeline (latency 2) and bypass (latency 1) instances side by side,
// each with its own BSRAM read model, checked against address/data scoreboards.
module tb_bsram_burst_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start_a, start_b, m_ready;
    logic [12:0] saddr;
    logic [8:0]  blen;

    logic        busy_a, done_a, ceb_a, oce_a, resetb_a, m_valid_a;
    logic        busy_b, done_b, ceb_b, oce_b, resetb_b, m_valid_b;
    logic [12:0] adb_a, adb_b;
    logic [7:0]  dout_a, m_data_a, cs_a, dout_b, m_data_b, cs_b;

    logic [7:0]  mem [8192];
    logic [7:0]  r1_a, r2_a, r1_b;

    int total = 0;
    int bad   = 0;

    logic [7:0]  qd_a[$], qd_b[$];
    logic [12:0] qa_a[$], qa_b[$];
    logic [7:0]  exp_cs;
    bit          len0_flag = 1'b0;

    int iss_a = 0, pops_a = 0, max_a = 0, out_a, mv_a = 0, bcyc_a = 0, dcnt_a = 0;
    int iss_b = 0, pops_b = 0, max_b = 0, out_b, mv_b = 0, bcyc_b = 0, dcnt_b = 0;
    bit prev_stall_a = 1'b0, prev_done_a = 1'b0, last_pop_a = 1'b0;
    bit prev_stall_b = 1'b0, prev_done_b = 1'b0, last_pop_b = 1'b0;
    logic [7:0] prev_data_a, prev_data_b;

    bsram_burst_reader #(.READ_LATENCY(2)) dut_a (
        .MEMORY_CLK(clk), .rst_n(rst_n), .start(start_a), .start_addr(saddr), .burst_len(blen),
        .busy(busy_a), .done(done_a), .adb(adb_a), .ceb(ceb_a), .oce(oce_a), .resetb(resetb_a),
        .dout(dout_a), .m_valid(m_valid_a), .m_data(m_data_a), .m_ready(m_ready), .checksum(cs_a));

    bsram_burst_reader #(.READ_LATENCY(1)) dut_b (
        .MEMORY_CLK(clk), .rst_n(rst_n), .start(start_b), .start_addr(saddr), .burst_len(blen),
        .busy(busy_b), .done(done_b), .adb(adb_b), .ceb(ceb_b), .oce(oce_b), .resetb(resetb_b),
        .dout(dout_b), .m_valid(m_valid_b), .m_data(m_data_b), .m_ready(m_ready), .checksum(cs_b));

    // BSRAM read port models: bypass for b, output register (oce) for a.
    always @(posedge clk) begin
        if (ceb_a) r1_a <= mem[adb_a];
        if (oce_a) r2_a <= r1_a;
        if (ceb_b) r1_b <= mem[adb_b];
    end
    assign dout_a = r2_a;
    assign dout_b = r1_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] cs_exp();
`ifdef RD_CHECKSUM_EN
        return exp_cs;
`else
        return 8'h00;
`endif
    endfunction

    // Monitor for the latency-2 instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            iss_a = 0; pops_a = 0; prev_stall_a = 1'b0; prev_done_a = 1'b0; last_pop_a = 1'b0;
        end else begin
            if (ceb_a) begin
                iss_a++;
                if (qa_a.size() == 0) chk("adb_extra_a", 32'(adb_a), 32'hFFFF_FFFF);
                else chk("adb_a", 32'(adb_a), 32'(qa_a.pop_front()));
            end
            out_a = iss_a - pops_a;
            if (out_a > max_a) max_a = out_a;
            if (prev_stall_a) begin
                chk("hold_valid_a", 32'(m_valid_a), 32'd1);
                chk("hold_data_a", 32'(m_data_a), 32'(prev_data_a));
            end
            if (m_valid_a) mv_a++;
            if (busy_a) bcyc_a++;
            if (m_valid_a && m_ready) begin
                if (qd_a.size() == 0) chk("data_extra_a", 32'(m_data_a), 32'hFFFF_FFFF);
                else chk("data_a", 32'(m_data_a), 32'(qd_a.pop_front()));
                pops_a++;
            end
            if (done_a) begin
                dcnt_a++;
                chk("done_busy_a", 32'(busy_a), 32'd1);
                chk("done_single_a", 32'(prev_done_a), 32'd0);
                chk("done_after_pop_a", 32'(last_pop_a | len0_flag), 32'd1);
                chk("done_all_out_a", 32'(qd_a.size()), 32'd0);
                chk("checksum_a", 32'(cs_a), 32'(cs_exp()));
            end
            prev_stall_a = m_valid_a && !m_ready;
            prev_data_a  = m_data_a;
            last_pop_a   = m_valid_a && m_ready;
            prev_done_a  = done_a;
        end
    end

    // Monitor for the latency-1 instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            iss_b = 0; pops_b = 0; prev_stall_b = 1'b0; prev_done_b = 1'b0; last_pop_b = 1'b0;
        end else begin
            if (ceb_b) begin
                iss_b++;
                if (qa_b.size() == 0) chk("adb_extra_b", 32'(adb_b), 32'hFFFF_FFFF);
                else chk("adb_b", 32'(adb_b), 32'(qa_b.pop_front()));
            end
            out_b = iss_b - pops_b;
            if (out_b > max_b) max_b = out_b;
            if (prev_stall_b) begin
                chk("hold_valid_b", 32'(m_valid_b), 32'd1);
                chk("hold_data_b", 32'(m_data_b), 32'(prev_data_b));
            end
            if (m_valid_b) mv_b++;
            if (busy_b) bcyc_b++;
            if (m_valid_b && m_ready) begin
                if (qd_b.size() == 0) chk("data_extra_b", 32'(m_data_b), 32'hFFFF_FFFF);
                else chk("data_b", 32'(m_data_b), 32'(qd_b.pop_front()));
                pops_b++;
            end
            if (done_b) begin
                dcnt_b++;
                chk("done_busy_b", 32'(busy_b), 32'd1);
                chk("done_single_b", 32'(prev_done_b), 32'd0);
                chk("done_after_pop_b", 32'(last_pop_b | len0_flag), 32'd1);
                chk("done_all_out_b", 32'(qd_b.size()), 32'd0);
                chk("checksum_b", 32'(cs_b), 32'(cs_exp()));
            end
            prev_stall_b = m_valid_b && !m_ready;
            prev_data_b  = m_data_b;
            last_pop_b   = m_valid_b && m_ready;
            prev_done_b  = done_b;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_burst(input logic [12:0] addr, input int len);
        logic [12:0] a;
        exp_cs = 8'h00;
        for (int i = 0; i < len; i++) begin
            a = addr + 13'(i);
            qa_a.push_back(a);
            qa_b.push_back(a);
            qd_a.push_back(mem[a]);
            qd_b.push_back(mem[a]);
            exp_cs = exp_cs + mem[a];
        end
    endtask

    task automatic start_burst(input logic [12:0] addr, input int len);
        push_burst(addr, len);
        saddr   = addr;
        blen    = 9'(len);
        start_a = 1'b1;
        start_b = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input int t, input bit rnd);
        int n = 0;
        while ((dcnt_a < t || dcnt_b < t) && n < 3000) begin
            if (rnd) m_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        chk("done_wait", 32'(dcnt_a >= t && dcnt_b >= t), 32'd1);
        m_ready = 1'b1;
        repeat (2) tick();
    endtask

    task automatic chk_reset();
        chk("rst_busy_a", 32'(busy_a), 32'd0);      chk("rst_busy_b", 32'(busy_b), 32'd0);
        chk("rst_done_a", 32'(done_a), 32'd0);      chk("rst_done_b", 32'(done_b), 32'd0);
        chk("rst_adb_a", 32'(adb_a), 32'd0);        chk("rst_adb_b", 32'(adb_b), 32'd0);
        chk("rst_ceb_a", 32'(ceb_a), 32'd0);        chk("rst_ceb_b", 32'(ceb_b), 32'd0);
        chk("rst_mvalid_a", 32'(m_valid_a), 32'd0); chk("rst_mvalid_b", 32'(m_valid_b), 32'd0);
        chk("rst_mdata_a", 32'(m_data_a), 32'd0);   chk("rst_mdata_b", 32'(m_data_b), 32'd0);
        chk("rst_cs_a", 32'(cs_a), 32'd0);          chk("rst_cs_b", 32'(cs_b), 32'd0);
        chk("oce_a", 32'(oce_a), 32'd1);            chk("oce_b", 32'(oce_b), 32'd1);
        chk("resetb_a", 32'(resetb_a), 32'd0);      chk("resetb_b", 32'(resetb_b), 32'd0);
    endtask

    initial begin
        int lat_a, lat_b, n, c0a, c0b, m0a, m0b, b0a, b0b;
        for (int i = 0; i < 8192; i++) mem[i] = 8'(i * 7 + 3);
        for (int i = 0; i < 128; i++) mem[13'h200 + 13'(i)] = 8'(i);
        mem[13'h1FFE] = 8'hA1; mem[13'h1FFF] = 8'hA2; mem[13'h0000] = 8'hA3; mem[13'h0001] = 8'hA4;

        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; m_ready = 1'b1; saddr = '0; blen = '0;
        repeat (3) tick();
        chk_reset();
        rst_n = 1'b1;
        repeat (2) tick();

        // 1: 128-byte burst, full throughput, latency to first byte.
        start_burst(13'h200, 128);
        lat_a = 0; lat_b = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            tick();
            if (m_valid_a && lat_a == 0) lat_a = cyc;
            if (m_valid_b && lat_b == 0) lat_b = cyc;
        end
        chk("latency_a", 32'(lat_a), 32'd4);
        chk("latency_b", 32'(lat_b), 32'd3);
        wait_done(1, 1'b0);
        chk("s1_pops_a", 32'(pops_a), 32'd128);
        chk("s1_pops_b", 32'(pops_b), 32'd128);

        // 2: same burst with a long stall then random backpressure.
        max_a = 0; max_b = 0;
        start_burst(13'h200, 128);
        repeat (30) tick();
        m_ready = 1'b0;
        repeat (20) tick();
        wait_done(2, 1'b1);
        chk("credit_max_a", 32'(max_a), 32'd4);
        chk("credit_max_b", 32'(max_b), 32'd4);

        // 3: address wrap at the top of the BSRAM.
        start_burst(13'h1FFE, 4);
        wait_done(3, 1'b0);
        chk("wrap_addrs_left", 32'(qa_a.size() + qa_b.size()), 32'd0);

        // 4: empty burst.
        c0a = iss_a; c0b = iss_b; m0a = mv_a; m0b = mv_b; b0a = bcyc_a; b0b = bcyc_b;
        len0_flag = 1'b1;
        start_burst(13'h123, 0);
        chk("len0_done_a", 32'(done_a), 32'd1); chk("len0_done_b", 32'(done_b), 32'd1);
        chk("len0_busy_a", 32'(busy_a), 32'd1); chk("len0_busy_b", 32'(busy_b), 32'd1);
        tick();
        chk("len0_done_off_a", 32'(done_a), 32'd0); chk("len0_busy_off_b", 32'(busy_b), 32'd0);
        repeat (3) tick();
        len0_flag = 1'b0;
        chk("len0_ceb_a", 32'(iss_a - c0a), 32'd0);     chk("len0_ceb_b", 32'(iss_b - c0b), 32'd0);
        chk("len0_mvalid_a", 32'(mv_a - m0a), 32'd0);   chk("len0_mvalid_b", 32'(mv_b - m0b), 32'd0);
        chk("len0_busycyc_a", 32'(bcyc_a - b0a), 32'd1); chk("len0_busycyc_b", 32'(bcyc_b - b0b), 32'd1);
        chk("len0_dcnt_a", 32'(dcnt_a), 32'd4);

        // 5a: start pulsed while busy is ignored.
        start_burst(13'h200, 16);
        repeat (5) tick();
        saddr = 13'h100; blen = 9'd3; start_a = 1'b1; start_b = 1'b1;
        tick();
        start_a = 1'b0; start_b = 1'b0;
        wait_done(5, 1'b0);
        repeat (4) tick();
        chk("busy_start_a", 32'(dcnt_a), 32'd5);
        chk("busy_start_b", 32'(dcnt_b), 32'd5);

        // 5b: start coinciding with done is ignored.
        start_burst(13'h210, 4);
        n = 0;
        while (!done_a && n < 200) begin
            tick();
            n++;
        end
        chk("s5b_done_seen", 32'(done_a), 32'd1);
        saddr = 13'h300; blen = 9'd2; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("done_start_busy", 32'(busy_a), 32'd0);
        repeat (4) tick();
        chk("done_start_busy_late", 32'(busy_a), 32'd0);
        chk("done_start_dcnt_a", 32'(dcnt_a), 32'd6);
        chk("done_start_dcnt_b", 32'(dcnt_b), 32'd6);

        // 5c: reset mid-burst, then a fresh burst.
        start_burst(13'h200, 64);
        repeat (20) tick();
        rst_n = 1'b0;
        tick();
        chk_reset();
        tick();
        qd_a.delete(); qd_b.delete(); qa_a.delete(); qa_b.delete();
        rst_n = 1'b1;
        tick();
        start_burst(13'h240, 32);
        wait_done(7, 1'b0);
        chk("fresh_pops_a", 32'(pops_a), 32'd32);
        chk("fresh_pops_b", 32'(pops_b), 32'd32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
